// File: rtl/fb_bram_arbiter_pkg.sv
// Shared definitions for the framebuffer BRAM arbiter: geometry defaults,
// scanout state encoding and RGB565 field positions.
package fb_bram_arbiter_pkg;

    localparam int HSIZE_DEF = 640;
    localparam int VSIZE_DEF = 480;
    localparam int AW_DEF    = 19;

    // RGB565 field positions inside a 16-bit pixel word
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    typedef enum logic [2:0] {
        SYNC,
        VBLANK,
        LINE,
        HBLANK,
        DONE
    } scan_state_t;

endpackage

// File: rtl/fb_scan_addrgen.sv
// Scanout address generator: frame/line state machine, per-line base address,
// pixel counter, line counter and the per-frame vertical flip latch.
module fb_scan_addrgen
    import fb_bram_arbiter_pkg::*;
#(
    parameter int HSIZE = HSIZE_DEF,
    parameter int VSIZE = VSIZE_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic          i_reverse_sw,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_black
);

    localparam int HW = $clog2(HSIZE);
    localparam int LW = $clog2(VSIZE + 1);

    localparam logic [AW-1:0] STEP      = AW'(HSIZE);
    localparam logic [AW-1:0] FLIP_BASE = AW'((VSIZE - 1) * HSIZE);
    localparam logic [HW-1:0] HLAST     = HW'(HSIZE - 1);

    scan_state_t   r_state;
    scan_state_t   w_state_next;
    logic [AW-1:0] r_base;
    logic [HW-1:0] r_hcnt;
    logic          r_hovf;
    logic [LW-1:0] r_line_cnt;
    logic          r_flip;

    logic          w_line_ok;
    logic          w_entry;
    logic          w_in_line;
    logic          w_line_end;
    logic [HW-1:0] w_idx;

    // A DE cycle that opens a line is already a pixel cycle, so entry is
    // decoded combinationally rather than waiting for the LINE state.
    assign w_line_ok  = r_line_cnt < LW'(VSIZE);
    assign w_entry    = i_vsync && i_de &&
                        ((r_state == VBLANK) || ((r_state == HBLANK) && w_line_ok));
    assign w_in_line  = w_entry || (i_vsync && i_de && (r_state == LINE));
    assign w_line_end = i_vsync && !i_de && (r_state == LINE);
    assign w_idx      = w_entry ? '0 : r_hcnt;

    assign o_rd_en   = w_entry || (w_in_line && !r_hovf);
    assign o_rd_addr = r_base + AW'(w_idx);
    assign o_black   = i_de && !o_rd_en;

    // State register; reset parks in DONE so nothing is read before a Vsync
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= DONE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; Vsync low overrides every state
    always_comb begin
        w_state_next = r_state;
        if (!i_vsync) begin
            w_state_next = SYNC;
        end else begin
            case (r_state)
                SYNC:    w_state_next = VBLANK;
                VBLANK:  if (i_de) w_state_next = LINE;
                LINE:    if (!i_de) w_state_next = HBLANK;
                HBLANK:  if (i_de) w_state_next = w_line_ok ? LINE : DONE;
                DONE:    w_state_next = DONE;
                default: w_state_next = DONE;
            endcase
        end
    end

    // Frame setup during SYNC, pixel counting in lines, base stepping per line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base     <= '0;
            r_hcnt     <= '0;
            r_hovf     <= 1'b0;
            r_line_cnt <= '0;
            r_flip     <= 1'b0;
        end else if (r_state == SYNC) begin
            r_flip     <= i_reverse_sw;
            r_base     <= i_reverse_sw ? FLIP_BASE : '0;
            r_line_cnt <= '0;
            r_hcnt     <= '0;
            r_hovf     <= 1'b0;
        end else begin
            if (w_entry) begin
                r_hcnt <= HW'(1);
                r_hovf <= 1'b0;
            end else if (w_in_line) begin
                // Saturate on the last pixel; the flag marks overlong cycles
                if (r_hcnt == HLAST) begin
                    r_hovf <= 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + HW'(1);
                end
            end
            if (w_line_end) begin
                r_line_cnt <= r_line_cnt + LW'(1);
                // Hold base on the final line so it stays inside the frame
                if ((r_line_cnt + LW'(1)) < LW'(VSIZE)) begin
                    if (r_flip) begin
                        r_base <= r_base - STEP;
                    end else begin
                        r_base <= r_base + STEP;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fb_bram_arbiter.sv
// Framebuffer BRAM arbiter: scanout owns the single BRAM port whenever DE is
// high, the host write channel owns it otherwise. Read data is turned into
// registered RGB565 pixels two cycles after the DE cycle that requested them.
module fb_bram_arbiter
    import fb_bram_arbiter_pkg::*;
#(
    parameter int HSIZE = HSIZE_DEF,
    parameter int VSIZE = VSIZE_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          Vsync,
    input  logic          DE,
    input  logic          Reverse_SW,
    output logic [AW-1:0] BRAMADDR,
    output logic          BRAMEN,
    output logic          BRAMWE,
    output logic [15:0]   BRAMWDATA,
    input  logic [15:0]   BRAMDATA,
    input  logic          WR_VALID,
    output logic          WR_READY,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [15:0]   WR_DATA,
    output logic [4:0]    R,
    output logic [5:0]    G,
    output logic [4:0]    B,
    output logic          DE_OUT
);

    localparam logic [AW:0] FB_WORDS = (AW + 1)'(HSIZE * VSIZE);

    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          w_black;
    logic          w_wr_accept;
    logic          w_wr_in_range;

    logic          r_de_d1;
    logic          r_blk_d1;
    logic          r_de_d2;
    logic [4:0]    r_red;
    logic [5:0]    r_green;
    logic [4:0]    r_blue;

    fb_scan_addrgen #(
        .HSIZE (HSIZE),
        .VSIZE (VSIZE),
        .AW    (AW)
    ) u_addrgen (
        .i_clk        (CLK),
        .i_rst_n      (RESET_N),
        .i_vsync      (Vsync),
        .i_de         (DE),
        .i_reverse_sw (Reverse_SW),
        .o_rd_en      (w_rd_en),
        .o_rd_addr    (w_rd_addr),
        .o_black      (w_black)
    );

    // Host is only granted outside active video; out-of-range writes are
    // still consumed but never reach the memory.
    assign WR_READY      = !DE;
    assign w_wr_accept   = WR_VALID && !DE;
    assign w_wr_in_range = {1'b0, WR_ADDR} < FB_WORDS;

    // Port mux; held at zero while reset is asserted
    always_comb begin
        BRAMEN    = 1'b0;
        BRAMWE    = 1'b0;
        BRAMADDR  = '0;
        BRAMWDATA = '0;
        if (RESET_N) begin
            if (DE) begin
                BRAMEN   = w_rd_en;
                BRAMADDR = w_rd_addr;
            end else if (w_wr_accept) begin
                BRAMEN    = w_wr_in_range;
                BRAMWE    = w_wr_in_range;
                BRAMADDR  = WR_ADDR;
                BRAMWDATA = WR_DATA;
            end
        end
    end

    // Two-stage pixel pipeline: stage 1 waits for BRAM latency, stage 2 splits RGB
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_de_d1  <= 1'b0;
            r_blk_d1 <= 1'b0;
            r_de_d2  <= 1'b0;
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
        end else begin
            r_de_d1  <= DE;
            r_blk_d1 <= w_black;
            r_de_d2  <= r_de_d1;
            if (r_de_d1 && !r_blk_d1) begin
                r_red   <= BRAMDATA[RGB_R_MSB:RGB_R_LSB];
                r_green <= BRAMDATA[RGB_G_MSB:RGB_G_LSB];
                r_blue  <= BRAMDATA[RGB_B_MSB:RGB_B_LSB];
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
        end
    end

    assign R      = r_red;
    assign G      = r_green;
    assign B      = r_blue;
    assign DE_OUT = r_de_d2;

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// Scoreboard bench for fb_bram_arbiter: stimulus pushes expected BRAM accesses
// and pixels; a negedge monitor pops and compares what the DUT presents.
module tb_fb_bram_arbiter;

    localparam int HS = 640;
    localparam int VS = 480;
    localparam int AW = 19;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic          Vsync, DE, Reverse_SW;
    logic [AW-1:0] BRAMADDR;
    logic          BRAMEN, BRAMWE;
    logic [15:0]   BRAMWDATA;
    logic [15:0]   BRAMDATA;
    logic          WR_VALID, WR_READY;
    logic [AW-1:0] WR_ADDR;
    logic [15:0]   WR_DATA;
    logic [4:0]    R;
    logic [5:0]    G;
    logic [4:0]    B;
    logic          DE_OUT;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wd;
    } acc_t;

    acc_t        exp_acc[$];
    logic [15:0] exp_pix[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] bram_q = 16'h0;

    always #5 CLK = ~CLK;

    fb_bram_arbiter #(.HSIZE(HS), .VSIZE(VS), .AW(AW)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .Vsync      (Vsync),
        .DE         (DE),
        .Reverse_SW (Reverse_SW),
        .BRAMADDR   (BRAMADDR),
        .BRAMEN     (BRAMEN),
        .BRAMWE     (BRAMWE),
        .BRAMWDATA  (BRAMWDATA),
        .BRAMDATA   (BRAMDATA),
        .WR_VALID   (WR_VALID),
        .WR_READY   (WR_READY),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .R          (R),
        .G          (G),
        .B          (B),
        .DE_OUT     (DE_OUT)
    );

    // Memory content is a fixed function of the address
    function automatic logic [15:0] pat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[18:16], a[18:16], 10'h0} ^ 16'h5A3C;
    endfunction

    // BRAM model with one cycle of read latency
    always @(posedge CLK) begin
        if (BRAMEN && !BRAMWE) bram_q <= pat(BRAMADDR);
    end
    assign BRAMDATA = bram_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every negedge, compare BRAM accesses and pixel outputs
    initial begin
        acc_t        e;
        logic [15:0] p;
        forever begin
            @(negedge CLK);
            if (BRAMEN) begin
                if (exp_acc.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_access: got we=%0b addr=%0d data=%0h required none at %0t",
                             BRAMWE, BRAMADDR, BRAMWDATA, $time);
                end else begin
                    e = exp_acc.pop_front();
                    check("bram_access", {BRAMWE, BRAMADDR, BRAMWDATA}, e);
                end
            end else begin
                check("we_without_en", BRAMWE, 1'b0);
            end
            if (DE_OUT) begin
                if (exp_pix.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %0h required none at %0t", {R, G, B}, $time);
                end else begin
                    p = exp_pix.pop_front();
                    check("pixel", {R, G, B}, p);
                end
            end else begin
                check("rgb_blank", {R, G, B}, 16'h0);
            end
        end
    end

    task automatic tick(input logic vs, input logic de, input logic rev, input logic wv,
                        input logic [AW-1:0] wa, input logic [15:0] wd);
        @(posedge CLK);
        #1;
        Vsync      = vs;
        DE         = de;
        Reverse_SW = rev;
        WR_VALID   = wv;
        WR_ADDR    = wa;
        WR_DATA    = wd;
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        exp_acc.push_back({1'b0, a, 16'h0});
        exp_pix.push_back(pat(a));
    endtask

    task automatic frame_start(input logic rev);
        repeat (3) tick(1'b0, 1'b0, rev, 1'b0, '0, '0);
        repeat (2) tick(1'b1, 1'b0, rev, 1'b0, '0, '0);
        $display("frame start: reverse=%0b t=%0t", rev, $time);
    endtask

    // One video line: n_de DE cycles reading from start, then n_blank blank cycles
    task automatic line(input int n_de, input logic [AW-1:0] start, input logic rd_on,
                        input int n_blank, input logic rev, input logic wv);
        for (int k = 0; k < n_de; k++) begin
            tick(1'b1, 1'b1, rev, wv, 19'd7, 16'h1111);
            if (rd_on && k < HS) push_read(start + AW'(k));
            else exp_pix.push_back(16'h0);
            if (wv && k == 0) begin
                #1;
                check("wr_ready_de_rise", WR_READY, 1'b0);
            end
            if (rd_on && k == HS + 10) begin
                #1;
                check("ovf_addr_hold", BRAMADDR, start + AW'(HS - 1));
                check("ovf_no_read", BRAMEN, 1'b0);
            end
        end
        for (int k = 0; k < n_blank; k++) tick(1'b1, 1'b0, rev, 1'b0, '0, '0);
        $display("line: start=%0d de=%0d reads=%0b t=%0t", start, n_de, rd_on, $time);
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [15:0] d, input logic accept);
        tick(1'b1, 1'b0, 1'b0, 1'b1, a, d);
        if (accept) exp_acc.push_back({1'b1, a, d});
        #1;
        check("wr_ready_blank", WR_READY, 1'b1);
        $display("host write: addr=%0d data=%0h expect_stored=%0b t=%0t", a, d, accept, $time);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bramen"}, BRAMEN, 1'b0);
        check({tag, "_bramwe"}, BRAMWE, 1'b0);
        check({tag, "_bramaddr"}, BRAMADDR, '0);
        check({tag, "_bramwdata"}, BRAMWDATA, 16'h0);
        check({tag, "_rgb"}, {R, G, B}, 16'h0);
        check({tag, "_de_out"}, DE_OUT, 1'b0);
    endtask

    initial begin
        RESET_N    = 1'b0;
        Vsync      = 1'b1;
        DE         = 1'b0;
        Reverse_SW = 1'b0;
        WR_VALID   = 1'b1;
        WR_ADDR    = 19'd100;
        WR_DATA    = 16'hABCD;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        check("reset_wr_ready", WR_READY, 1'b1);
        WR_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // After reset, no scanout reads until a Vsync
        line(10, '0, 1'b0, 4, 1'b0, 1'b0);

        // Normal frame with host contention between lines
        frame_start(1'b0);
        line(HS, 19'd0, 1'b1, 8, 1'b0, 1'b0);
        host_wr(19'd1234, 16'hBEEF, 1'b1);
        host_wr(19'd307200, 16'hDEAD, 1'b0);
        host_wr(19'd307199, 16'h1357, 1'b1);
        line(HS, 19'd640, 1'b1, 8, 1'b0, 1'b1);
        host_wr(19'd55, 16'h2468, 1'b1);
        line(HS, 19'd1280, 1'b1, 8, 1'b0, 1'b0);
        // Reverse_SW toggled mid-frame: still ascending
        line(HS, 19'd1920, 1'b1, 8, 1'b1, 1'b0);

        // Flip takes effect on the next frame
        frame_start(1'b1);
        line(HS, 19'd306560, 1'b1, 8, 1'b1, 1'b0);
        line(HS, 19'd305920, 1'b1, 8, 1'b1, 1'b0);

        // Overlong first line, then short lines up to the last valid line,
        // then two extra lines past the frame
        frame_start(1'b0);
        line(700, 19'd0, 1'b1, 8, 1'b0, 1'b0);
        for (int l = 1; l < VS - 1; l++) line(2, AW'(l * HS), 1'b1, 2, 1'b0, 1'b0);
        line(HS, 19'd306560, 1'b1, 8, 1'b0, 1'b0);
        line(10, '0, 1'b0, 4, 1'b0, 1'b0);
        line(10, '0, 1'b0, 4, 1'b0, 1'b0);

        // Reset in the middle of a line at hcnt=100
        frame_start(1'b0);
        line(HS, 19'd0, 1'b1, 8, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
            push_read(AW'(HS + k));
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        #2;
        RESET_N = 1'b0;
        #1;
        check_outputs_zero("midline_reset");
        check("midline_reset_acc_pending", exp_acc.size(), 0);
        $display("mid-line reset: %0d in-flight pixels aborted t=%0t", exp_pix.size(), $time);
        exp_pix.delete();
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        RESET_N = 1'b1;
        line(20, '0, 1'b0, 4, 1'b0, 1'b0);
        frame_start(1'b0);
        line(5, 19'd0, 1'b1, 8, 1'b0, 1'b0);

        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("acc_queue_drained", exp_acc.size(), 0);
        check("pix_queue_drained", exp_pix.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
